// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Ports: clk, rst, start, bin -> busy, done, bcd, ovf (handshake + held result).
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BIN_W-1:0] r_shreg;
  logic [BW-1:0]   r_scratch;
  logic [BW-1:0]   w_adj;
  logic            r_ovf_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic [BW-1:0]   r_bcd;
  logic            r_ovf;
  logic            w_last;

  // add-3 on every digit >= 5 before the shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] =
      (r_scratch[4*g +: 4] >= 4'd5) ?
      r_scratch[4*g +: 4] + 4'd3 :
      r_scratch[4*g +: 4];
  end

  assign w_last = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_scratch <= '0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shreg   <= bin;
            r_scratch <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= CW'(BIN_W);
          end
        end
        S_SHIFT: begin
          r_scratch <= {w_adj[BW-2:0], r_shreg[BIN_W-1]};
          r_shreg   <= {r_shreg[BIN_W-2:0], 1'b0};
          // a bit leaving the top digit means value >= 10^DIGITS
          r_ovf_acc <= r_ovf_acc | w_adj[BW-1];
          r_cnt     <= r_cnt - CW'(1);
        end
        S_DONE: begin
          r_bcd  <= r_scratch;
          r_ovf  <= r_ovf_acc;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: 3-digit and 2-digit instances share stimulus,
// results compared with a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
  );

  function automatic logic [15:0] ref_bcd(input int v, input int d);
    int m, p;
    logic [15:0] r;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    m = v % p;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Called at a negedge; issues start immediately and returns at the
  // negedge where done is seen (lat = -1 if it never comes).
  task automatic convert(
    input  logic [7:0]  b,
    input  bit          hold,
    output int          lat,
    output int          nb,
    output logic [11:0] r3,
    output logic        o3,
    output logic [7:0]  r2,
    output logic        o2
  );
    lat = -1;
    nb  = 0;
    r3  = 'x; o3 = 'x; r2 = 'x; o2 = 'x;
    start = 1'b1;
    bin   = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy3) nb++;
      if (done3) begin
        lat = k;
        r3 = bcd3; o3 = ovf3; r2 = bcd2; o2 = ovf2;
        break;
      end
      if (!hold) start = 1'b0;
      bin = 8'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = 8'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy3, done3, bcd3, ovf3} !== 15'd0) begin
      bad++;
      $display("FAIL reset3 got busy=%b done=%b bcd=%h ovf=%b want all 0",
               busy3, done3, bcd3, ovf3);
    end
    total++;
    if ({busy2, done2, bcd2, ovf2} !== 11'd0) begin
      bad++;
      $display("FAIL reset2 got busy=%b done=%b bcd=%h ovf=%b want all 0",
               busy2, done2, bcd2, ovf2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat, nb;
    logic [11:0] r3; logic [7:0] r2; logic o3, o2;
    convert(8'd0, 1'b0, lat, nb, r3, o3, r2, o2);
    total++;
    if (lat !== 10) begin
      bad++; $display("FAIL zero_latency got %0d want 10", lat);
    end
    total++;
    if (nb !== 8) begin
      bad++; $display("FAIL zero_busy got %0d want 8", nb);
    end
    total++;
    if ({r3, o3} !== 13'd0) begin
      bad++; $display("FAIL zero_result got %h/%b want 000/0", r3, o3);
    end
  endtask

  task automatic test_known();
    logic [7:0] vals [3] = '{8'd255, 8'd99, 8'd100};
    int lat, nb;
    logic [11:0] r3, e3; logic [7:0] r2; logic o3, o2;
    foreach (vals[i]) begin
      e3 = ref_bcd(int'(vals[i]), 3)[11:0];
      convert(vals[i], 1'b0, lat, nb, r3, o3, r2, o2);
      total++;
      if (r3 !== e3 || o3 !== 1'b0 || lat !== 10) begin
        bad++;
        $display("FAIL known bin=%0d got %h/%b lat=%0d want %h/0 lat=10",
                 vals[i], r3, o3, lat, e3);
      end
      @(negedge clk);
      total++;
      if (done3 !== 1'b0 || bcd3 !== e3) begin
        bad++;
        $display("FAIL known_pulse bin=%0d got done=%b bcd=%h want 0/%h",
                 vals[i], done3, bcd3, e3);
      end
    end
  endtask

  task automatic test_sweep();
    int lat, nb;
    logic [11:0] r3, e3; logic [7:0] r2, e2; logic o3, o2;
    int nbad;
    for (int v = 0; v < 256; v++) begin
      e3 = ref_bcd(v, 3)[11:0];
      e2 = ref_bcd(v, 2)[7:0];
      convert(8'(v), 1'b0, lat, nb, r3, o3, r2, o2);
      total++;
      if (lat !== 10 || nb !== 8 || r3 !== e3 || o3 !== 1'b0) begin
        bad++;
        $display("FAIL sweep3 bin=%0d got %h/%b lat=%0d busy=%0d want %h/0 10/8",
                 v, r3, o3, lat, nb, e3);
      end
      total++;
      if (r2 !== e2 || o2 !== (v >= 100)) begin
        bad++;
        $display("FAIL sweep2 bin=%0d got %h/%b want %h/%b",
                 v, r2, o2, e2, (v >= 100));
      end
      nbad = 0;
      for (int i = 0; i < 3; i++)
        if (r3[4*i +: 4] > 4'd9) nbad++;
      for (int i = 0; i < 2; i++)
        if (r2[4*i +: 4] > 4'd9) nbad++;
      total++;
      if (nbad !== 0) begin
        bad++;
        $display("FAIL sweep_digit bin=%0d got %h/%h bad nibbles=%0d want 0",
                 v, r3, r2, nbad);
      end
    end
  endtask

  task automatic test_hold();
    int lat, nb, extra, eb;
    logic [7:0] b;
    logic [11:0] r3, e3; logic [7:0] r2; logic o3, o2;
    b  = 8'($urandom_range(1, 255));
    e3 = ref_bcd(int'(b), 3)[11:0];
    convert(b, 1'b1, lat, nb, r3, o3, r2, o2);
    total++;
    if (r3 !== e3 || lat !== 10) begin
      bad++;
      $display("FAIL hold bin=%0d got %h lat=%0d want %h lat=10",
               b, r3, lat, e3);
    end
    extra = 0; eb = 0;
    repeat (15) begin
      @(negedge clk);
      if (done3) extra++;
      if (busy3) eb++;
    end
    total++;
    if (extra !== 0 || eb !== 0) begin
      bad++;
      $display("FAIL hold_extra got done=%0d busy=%0d want 0/0", extra, eb);
    end
  endtask

  task automatic test_abort();
    int lat, nb, extra;
    logic [11:0] r3; logic [7:0] r2; logic o3, o2;
    convert(8'd123, 1'b0, lat, nb, r3, o3, r2, o2);
    start = 1'b1; bin = 8'd200;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      bin = 8'($urandom);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || bcd3 !== 12'h000 ||
        bcd2 !== 8'h00 || ovf3 !== 1'b0) begin
      bad++;
      $display("FAIL abort got busy=%b done=%b bcd=%h/%h ovf=%b want 0",
               busy3, done3, bcd3, bcd2, ovf3);
    end
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done3 || busy3) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL abort_quiet got %0d want 0", extra);
    end
    convert(8'd7, 1'b0, lat, nb, r3, o3, r2, o2);
    total++;
    if (r3 !== 12'h007 || lat !== 10) begin
      bad++;
      $display("FAIL abort_next got %h lat=%0d want 007 lat=10", r3, lat);
    end
  endtask

  task automatic test_random_ovf();
    int lat, nb;
    logic [7:0] b;
    logic [11:0] r3; logic [7:0] r2, e2; logic o3, o2;
    for (int n = 0; n < 20; n++) begin
      b  = 8'($urandom);
      e2 = ref_bcd(int'(b), 2)[7:0];
      convert(b, 1'b0, lat, nb, r3, o3, r2, o2);
      total++;
      if (r2 !== e2 || o2 !== (b >= 8'd100)) begin
        bad++;
        $display("FAIL rand2 bin=%0d got %h/%b want %h/%b",
                 b, r2, o2, e2, (b >= 8'd100));
      end
    end
    convert(8'd100, 1'b0, lat, nb, r3, o3, r2, o2);
    total++;
    if (r2 !== 8'h00 || o2 !== 1'b1) begin
      bad++; $display("FAIL ovf100 got %h/%b want 00/1", r2, o2);
    end
    convert(8'd99, 1'b0, lat, nb, r3, o3, r2, o2);
    total++;
    if (r2 !== 8'h99 || o2 !== 1'b0) begin
      bad++; $display("FAIL ovf99 got %h/%b want 99/0", r2, o2);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = 8'd0;
    test_reset();
    test_zero();
    test_known();
    test_sweep();
    test_hold();
    test_abort();
    test_random_ovf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
